// File: rtl/sp_ram_req_ctrl.sv
// sp_ram_req_ctrl
//   Request-side controller in front of a single-port RAM. It turns valid/ready
//   read/write requests into legal RAM pin sequences and returns read data on a
//   backpressured response channel through a 2-entry first-word-fall-through FIFO.
//
// Ports
//   clk, rst           : clock, synchronous active-high reset
//   req_valid/ready    : request handshake; req_we selects write (1) or read (0)
//   req_addr/req_wdata : request address and write data
//   rsp_valid/ready    : response handshake; rsp_data is the read data
//   mem_cs/we/oe       : RAM control pins
//   mem_address        : RAM address
//   mem_data_out       : write data toward RAM, mem_data_drive enables the bus driver
//   mem_data_in        : read data from RAM
//   wr_count/rd_count  : (SP_RAM_REQ_WR_COUNT_EN only) accepted write/read counters
//
// Optional build macro: SP_RAM_REQ_WR_COUNT_EN adds the wr_count/rd_count outputs.
module sp_ram_req_ctrl #(
  parameter int DATA_WIDTH    = 8,
  parameter int ADDRESS_WIDTH = 30,
  parameter int RD_LAT        = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic                     req_we,
  input  logic [ADDRESS_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0]    req_wdata,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [DATA_WIDTH-1:0]    rsp_data,
  output logic                     mem_cs,
  output logic                     mem_we,
  output logic                     mem_oe,
  output logic [ADDRESS_WIDTH-1:0] mem_address,
  output logic [DATA_WIDTH-1:0]    mem_data_out,
  output logic                     mem_data_drive,
  input  logic [DATA_WIDTH-1:0]    mem_data_in
`ifdef SP_RAM_REQ_WR_COUNT_EN
  ,
  output logic [31:0]              wr_count,
  output logic [31:0]              rd_count
`endif
);

  typedef enum logic [1:0] {IDLE, WRITE, READ, TURN} state_t;

  localparam logic [2:0] RD_LAT_L = 3'(RD_LAT);

  state_t                  state, state_nxt;
  logic [2:0]              rd_cnt;
  logic                    accept, read_last, inflight;
  // Read data is captured on the last READ cycle and enters the FIFO one edge
  // later, which gives the RD_LAT+2 acceptance-to-rsp_valid latency.
  logic                    cap_vld;
  logic [DATA_WIDTH-1:0]   cap_data;
  logic [DATA_WIDTH-1:0]   fifo_mem [2];
  logic                    wr_ptr, rd_ptr;
  logic [1:0]              count;
  logic                    push, pop;

  // A read counts against FIFO space from acceptance until its push lands.
  assign inflight  = (state == READ) || cap_vld;
  assign req_ready = !rst && (state == IDLE) &&
                     (({1'b0, count} + {2'b00, inflight}) < 3'd2);
  assign accept    = req_valid && req_ready;
  assign read_last = (state == READ) && (rd_cnt == 3'd0);

  always_comb begin
    state_nxt      = state;
    mem_cs         = 1'b0;
    mem_we         = 1'b0;
    mem_oe         = 1'b0;
    mem_data_drive = 1'b0;
    case (state)
      IDLE:  if (accept) state_nxt = req_we ? WRITE : READ;
      WRITE: begin
        mem_cs         = 1'b1;
        mem_we         = 1'b1;
        mem_data_drive = 1'b1;
        state_nxt      = IDLE;
      end
      READ: begin
        mem_cs = 1'b1;
        mem_oe = 1'b1;
        if (rd_cnt == 3'd0) state_nxt = TURN;
      end
      TURN:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      rd_cnt       <= 3'd0;
      mem_address  <= '0;
      mem_data_out <= '0;
      cap_vld      <= 1'b0;
      cap_data     <= '0;
    end else begin
      state   <= state_nxt;
      cap_vld <= read_last;
      if (read_last) cap_data <= mem_data_in;
      // Address/data registers only move on acceptance, i.e. only in IDLE.
      if (accept) begin
        mem_address <= req_addr;
        if (req_we) mem_data_out <= req_wdata;
        else        rd_cnt       <= RD_LAT_L;
      end else if ((state == READ) && (rd_cnt != 3'd0)) begin
        rd_cnt <= rd_cnt - 3'd1;
      end
    end
  end

  // Response FIFO: push and pop in one cycle leave count unchanged.
  assign push      = cap_vld;
  assign rsp_valid = (count != 2'd0);
  assign pop       = rsp_valid && rsp_ready;
  assign rsp_data  = rsp_valid ? fifo_mem[rd_ptr] : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      count       <= 2'd0;
      wr_ptr      <= 1'b0;
      rd_ptr      <= 1'b0;
      fifo_mem[0] <= '0;
      fifo_mem[1] <= '0;
    end else begin
      if (push) begin
        fifo_mem[wr_ptr] <= cap_data;
        wr_ptr           <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

`ifdef SP_RAM_REQ_WR_COUNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_count <= '0;
      rd_count <= '0;
    end else if (accept) begin
      if (req_we) wr_count <= wr_count + 32'd1;
      else        rd_count <= rd_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_sp_ram_req_ctrl.sv
// Testbench for sp_ram_req_ctrl: directed scenarios plus randomized traffic.
// A monitor derives the expected read data from accepted requests using a
// plain memory array, queues it, and compares whenever a response is taken.
// It also checks the RAM pin sequences seen on every cycle.
module tb_sp_ram_req_ctrl;
  localparam int DW = 8;
  localparam int AW = 30;
  localparam int RD_LAT = 3;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          req_valid = 1'b0, req_ready, req_we = 1'b0;
  logic [AW-1:0] req_addr = '0;
  logic [DW-1:0] req_wdata = '0;
  logic          rsp_valid, rsp_ready = 1'b1;
  logic [DW-1:0] rsp_data;
  logic          mem_cs, mem_we, mem_oe, mem_data_drive;
  logic [AW-1:0] mem_address;
  logic [DW-1:0] mem_data_out, mem_data_in = '0;
`ifdef SP_RAM_REQ_WR_COUNT_EN
  logic [31:0]   wr_count, rd_count;
`endif

  sp_ram_req_ctrl #(.DATA_WIDTH(DW), .ADDRESS_WIDTH(AW), .RD_LAT(RD_LAT)) u_dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .mem_cs(mem_cs), .mem_we(mem_we), .mem_oe(mem_oe),
    .mem_address(mem_address), .mem_data_out(mem_data_out),
    .mem_data_drive(mem_data_drive), .mem_data_in(mem_data_in)
`ifdef SP_RAM_REQ_WR_COUNT_EN
    , .wr_count(wr_count), .rd_count(rd_count)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int fails  = 0;
  int cyc    = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%0h exp=%0h (cycle %0d)", nm, got, exp, cyc);
    end
  endtask

  // RAM model: writes land on the edge, reads show the array when oe is high
  // and garbage otherwise so sampling outside the read window shows up.
  logic [DW-1:0] ram [logic [AW-1:0]];
  always @(posedge clk) if (mem_cs && mem_we) ram[mem_address] = mem_data_out;
  always @(negedge clk) begin
    if (mem_oe && ram.exists(mem_address)) mem_data_in = ram[mem_address];
    else if (mem_oe)                       mem_data_in = '0;
    else                                   mem_data_in = DW'($urandom);
  end

  // Reference model and monitor
  logic [DW-1:0] ref_mem [logic [AW-1:0]];
  logic [DW-1:0] exp_q [$];
  logic [AW-1:0] acc_addr = '0;
  logic [DW-1:0] acc_data = '0;
  int  last_rd_acc = 0, oe_run = 0, nwr = 0, nrd = 0;
  logic prev_cs = 1'b0, prev_oe = 1'b0, prev_rsp_valid = 1'b0;

  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      oe_run = 0; nwr = 0; nrd = 0;
      prev_cs = 1'b0; prev_oe = 1'b0; prev_rsp_valid = 1'b0;
    end else begin
      if (rsp_valid && !prev_rsp_valid) chk("rsp_latency", cyc - last_rd_acc, RD_LAT + 2);
      if (rsp_valid && rsp_ready) begin
        if (exp_q.size() == 0) chk("rsp_unexpected", 32'(rsp_data), 32'hFFFF_FFFF);
        else                   chk("rsp_data", 32'(rsp_data), 32'(exp_q.pop_front()));
      end
      if (mem_cs) chk("we_and_oe", 32'(mem_we && mem_oe), 0);
      if (!mem_cs) chk("ctl_when_idle", {29'b0, mem_we, mem_oe, mem_data_drive}, 0);
      if (mem_we) begin
        chk("wr_pins", {28'b0, mem_cs, mem_data_drive, mem_oe, prev_cs}, 32'b1100);
        chk("wr_addr", 32'(mem_address), 32'(acc_addr));
        chk("wr_data", 32'(mem_data_out), 32'(acc_data));
      end
      if (mem_oe) begin
        oe_run++;
        chk("rd_pins", {29'b0, mem_cs, mem_we, mem_data_drive}, 32'b100);
        chk("rd_addr", 32'(mem_address), 32'(acc_addr));
      end
      if (!mem_oe && prev_oe) begin
        chk("rd_cycles", oe_run, RD_LAT + 1);
        chk("turn_cs", 32'(mem_cs), 0);
        oe_run = 0;
      end
      if (req_valid && req_ready) begin
        acc_addr = req_addr;
        if (req_we) begin
          acc_data = req_wdata;
          ref_mem[req_addr] = req_wdata;
          nwr++;
        end else begin
          exp_q.push_back(ref_mem.exists(req_addr) ? ref_mem[req_addr] : '0);
          last_rd_acc = cyc + 1;
          nrd++;
        end
      end
      prev_cs = mem_cs; prev_oe = mem_oe; prev_rsp_valid = rsp_valid;
    end
  end

  // Random consumer backpressure when enabled
  bit rand_rdy = 1'b0;
  always @(posedge clk) if (rand_rdy) begin #1; rsp_ready = ($urandom_range(0, 3) != 0); end

  task automatic send(input bit we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    int n = 0;
    req_valid = 1'b1; req_we = we; req_addr = a; req_wdata = d;
    @(negedge clk);
    while (!req_ready && n < 200) begin @(negedge clk); n++; end
    if (!req_ready) chk("req_timeout", 0, 1);
    @(posedge clk); #1;
    req_valid = 1'b0; req_wdata = DW'($urandom);
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 500) begin @(negedge clk); n++; end
    chk("drain_empty", exp_q.size(), 0);
  endtask

  initial begin
    logic [AW-1:0] ones;
    logic [AW-1:0] a;
    bit saw;
    ones = '1;

    // Reset held 3 cycles with a pending request
    rst = 1'b1; req_valid = 1'b1; req_we = 1'b0; req_addr = 30'h10;
    repeat (3) begin
      @(negedge clk);
      chk("rst_ctl", {26'b0, mem_cs, mem_we, mem_oe, mem_data_drive, req_ready, rsp_valid}, 0);
      chk("rst_addr", 32'(mem_address), 0);
      chk("rst_dout", 32'(mem_data_out), 0);
      chk("rst_rdata", 32'(rsp_data), 0);
    end
    @(posedge clk); #1; rst = 1'b0; req_valid = 1'b0;
    @(negedge clk);
    chk("ready_after_rst", 32'(req_ready), 1);

    // Write then read back
    send(1'b1, 30'h10, 8'hA5);
    send(1'b0, 30'h10, 8'h00);
    drain();

    // Backpressure: two reads fill the FIFO, a third stalls
    send(1'b1, 30'h1, 8'h11);
    send(1'b1, 30'h2, 8'h22);
    send(1'b1, 30'h3, 8'h33);
    rsp_ready = 1'b0;
    send(1'b0, 30'h1, 8'h00);
    send(1'b0, 30'h2, 8'h00);
    req_valid = 1'b1; req_we = 1'b0; req_addr = 30'h3;
    repeat (RD_LAT + 8) @(negedge clk);
    chk("stall_ready", 32'(req_ready), 0);
    chk("fifo_head", {23'b0, rsp_valid, rsp_data}, 32'h111);
    @(posedge clk); #1; rsp_ready = 1'b1;
    send(1'b0, 30'h3, 8'h00);
    drain();

    // Read-to-write turnaround at the all-ones address
    send(1'b0, ones, 8'h00);
    send(1'b1, ones, 8'h5A);
    send(1'b0, ones, 8'h00);
    drain();

    // Randomized traffic with random consumer stalls
    rand_rdy = 1'b1;
    for (int i = 0; i < 80; i++) begin
      case ($urandom_range(0, 4))
        0:       a = '0;
        1:       a = ones;
        default: a = AW'($urandom_range(0, 7));
      endcase
      send($urandom_range(0, 1) == 1, a, DW'($urandom));
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
    end
    rand_rdy = 1'b0;
    @(posedge clk); #1; rsp_ready = 1'b1;
    drain();

`ifdef SP_RAM_REQ_WR_COUNT_EN
    @(negedge clk);
    chk("wr_count", wr_count, nwr);
    chk("rd_count", rd_count, nrd);
    @(posedge clk); #1; rst = 1'b1;
    @(posedge clk); #1; rst = 1'b0;
    @(negedge clk);
    chk("wr_count_rst", wr_count, 0);
    chk("rd_count_rst", rd_count, 0);
`endif

    // Reset during the 2nd READ cycle aborts the read
    send(1'b0, 30'h10, 8'h00);
    @(posedge clk); #1; rst = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("abort_cs", {30'b0, mem_cs, mem_oe}, 0);
    @(posedge clk); #1; rst = 1'b0;
    saw = 1'b0;
    repeat (RD_LAT + 6) begin
      @(negedge clk);
      if (rsp_valid) saw = 1'b1;
    end
    chk("abort_no_rsp", 32'(saw), 0);
    chk("abort_ready", 32'(req_ready), 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "timeout");
  end
endmodule
